alu_ctrl_encode: RTL and testbench

- ID-stage block that produces the 4-bit ALU control code consumed by the EX-stage ALU control decoder.
- Extracts opcode, funct3 and funct7 from a 32-bit RV32I instruction, derives the control code, operand selects and an illegal flag, and registers them into the ID/EX boundary.
- Uses a valid/ready handshake on both sides, plus stall and flush, so it stands in as the ALU-control slice of the ID/EX pipeline register.

---
 rtl/alu_ctrl_encode.sv | 174 +++++++++++++++++
 tb/tb_alu_ctrl_encode.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_encode.sv
// ID-stage ALU control encoder: decodes an RV32I word into the ALU control code and operand selects,
// and registers the result at the ID/EX boundary. Optional illegal counter: ALU_ILLEGAL_CNT_EN.
module alu_ctrl_encode #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_ctr,
    output logic [1:0]       out_src_a_sel,
    output logic             out_src_b_sel,
    output logic             out_illegal
`ifdef ALU_ILLEGAL_CNT_EN
    ,
    output logic [CNT_W-1:0] illegal_cnt
`endif
);

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;

    localparam logic [1:0] SrcARs1  = 2'b00;
    localparam logic [1:0] SrcAPc   = 2'b01;
    localparam logic [1:0] SrcAZero = 2'b10;

    localparam logic [6:0] F7Zero = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    // Register and immediate fields play no part in the ALU control code.
    logic unused_fields;
    assign unused_fields = ^{in_instr[24:15], in_instr[11:7]};

    logic [3:0] dec_ctr;
    logic [1:0] dec_src_a;
    logic       dec_src_b;
    logic       dec_illegal;

    always_comb begin
        dec_ctr     = 4'b0000;
        dec_src_a   = SrcARs1;
        dec_src_b   = 1'b0;
        dec_illegal = 1'b0;

        case (opcode)
            OpcOp: begin
                dec_ctr = {funct7[5], funct3};
                if (funct7 == F7Zero) begin
                    dec_illegal = 1'b0;
                end else if (funct7 == F7Alt && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    dec_illegal = 1'b0;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OpcOpImm: begin
                dec_src_b = 1'b1;
                if (funct3 == 3'b001) begin
                    dec_ctr     = 4'b0001;
                    dec_illegal = (funct7 != F7Zero);
                end else if (funct3 == 3'b101) begin
                    dec_ctr     = {funct7[5], 3'b101};
                    dec_illegal = (funct7 != F7Zero) && (funct7 != F7Alt);
                end else begin
                    // Upper bits are immediate here, so funct7 is not checked.
                    dec_ctr = {1'b0, funct3};
                end
            end
            OpcLoad, OpcStore, OpcJalr: begin
                dec_src_b = 1'b1;
            end
            OpcAuipc, OpcJal, OpcBranch: begin
                dec_src_a = SrcAPc;
                dec_src_b = 1'b1;
            end
            OpcLui: begin
                dec_src_a = SrcAZero;
                dec_src_b = 1'b1;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase

        if (dec_illegal) begin
            dec_ctr   = 4'b0000;
            dec_src_a = SrcARs1;
            dec_src_b = 1'b0;
        end
    end

    logic       valid_q, valid_d;
    logic [3:0] ctr_q;
    logic [1:0] src_a_q;
    logic       src_b_q;
    logic       illegal_q;
    logic       accept;

    assign in_ready = ~valid_q | out_ready;
    assign accept   = in_valid & in_ready & ~flush;

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            ctr_q     <= 4'b0000;
            src_a_q   <= 2'b00;
            src_b_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                ctr_q     <= dec_ctr;
                src_a_q   <= dec_src_a;
                src_b_q   <= dec_src_b;
                illegal_q <= dec_illegal;
            end
        end
    end

    assign out_valid     = valid_q;
    assign out_ctr       = ctr_q;
    assign out_src_a_sel = src_a_q;
    assign out_src_b_sel = src_b_q;
    assign out_illegal   = illegal_q;

`ifdef ALU_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturates at all-ones; accept already excludes flushed cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept && dec_illegal && !(&cnt_q)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign illegal_cnt = cnt_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_encode.sv
// Self-checking bench for alu_ctrl_encode: directed scenarios plus randomized traffic against a
// mnemonic-level reference model. Counter checks are built only with ALU_ILLEGAL_CNT_EN.
module tb_alu_ctrl_encode;

    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b1000, SLL = 4'b0001, SLT = 4'b0010;
    localparam logic [3:0] SLTU = 4'b0011, XOR = 4'b0100, SRL = 4'b0101, SRA = 4'b1101;
    localparam logic [3:0] OR = 4'b0110, AND = 4'b0111;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_ctr;
    logic [1:0]  out_src_a_sel;
    logic        out_src_b_sel;
    logic        out_illegal;

    int n_cmp = 0;
    int n_err = 0;

    // Expected registered state
    logic       exp_valid;
    logic [3:0] exp_ctr;
    logic [1:0] exp_a;
    logic       exp_b;
    logic       exp_ill;

`ifdef ALU_ILLEGAL_CNT_EN
    logic [15:0] cnt16;
    logic [1:0]  cnt2;
    logic        d2_in_ready, d2_out_valid, d2_b, d2_ill;
    logic [3:0]  d2_ctr;
    logic [1:0]  d2_a;
    int          exp_cnt;
    int          exp_cnt2;
`endif

    always #5 clk = ~clk;

    alu_ctrl_encode dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ctr       (out_ctr),
        .out_src_a_sel (out_src_a_sel),
        .out_src_b_sel (out_src_b_sel),
        .out_illegal   (out_illegal)
`ifdef ALU_ILLEGAL_CNT_EN
        ,
        .illegal_cnt   (cnt16)
`endif
    );

`ifdef ALU_ILLEGAL_CNT_EN
    alu_ctrl_encode #(.CNT_W(2)) dut2 (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (d2_in_ready),
        .in_instr      (in_instr),
        .flush         (flush),
        .out_valid     (d2_out_valid),
        .out_ready     (out_ready),
        .out_ctr       (d2_ctr),
        .out_src_a_sel (d2_a),
        .out_src_b_sel (d2_b),
        .out_illegal   (d2_ill),
        .illegal_cnt   (cnt2)
    );
`endif

    function automatic logic [3:0] base_op(input logic [2:0] f3);
        case (f3)
            3'd0: base_op = ADD;
            3'd1: base_op = SLL;
            3'd2: base_op = SLT;
            3'd3: base_op = SLTU;
            3'd4: base_op = XOR;
            3'd5: base_op = SRL;
            3'd6: base_op = OR;
            default: base_op = AND;
        endcase
    endfunction

    // Returns {illegal, src_b, src_a[1:0], ctr[3:0]}
    function automatic logic [7:0] ref_dec(input logic [31:0] i);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] c;
        logic [1:0] a;
        logic       b;
        logic       ill;
        opc = i[6:0];
        f3  = i[14:12];
        f7  = i[31:25];
        c   = ADD;
        a   = 2'd0;
        b   = 1'b0;
        ill = 1'b0;
        case (opc)
            7'b0110011: begin
                if (f7 == 7'h00) c = base_op(f3);
                else if (f7 == 7'h20 && f3 == 3'd0) c = SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) c = SRA;
                else ill = 1'b1;
            end
            7'b0010011: begin
                b = 1'b1;
                if (f3 == 3'd1) begin
                    c = SLL;
                    if (f7 != 7'h00) ill = 1'b1;
                end else if (f3 == 3'd5) begin
                    if (f7 == 7'h00) c = SRL;
                    else if (f7 == 7'h20) c = SRA;
                    else ill = 1'b1;
                end else begin
                    c = base_op(f3);
                end
            end
            7'b0000011, 7'b0100011, 7'b1100111: b = 1'b1;
            7'b0010111, 7'b1101111, 7'b1100011: begin
                a = 2'd1;
                b = 1'b1;
            end
            7'b0110111: begin
                a = 2'd2;
                b = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            c = ADD;
            a = 2'd0;
            b = 1'b0;
        end
        ref_dec = {ill, b, a, c};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [12];
        logic [31:0] w;
        int sel;
        opcs = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011, 7'b0000011, 7'b0100011,
                 7'b1100111, 7'b0010111, 7'b1101111, 7'b1100011, 7'b0110111, 7'b0000000};
        w   = $urandom;
        sel = int'($urandom_range(0, 12));
        if (sel < 12) w[6:0] = opcs[sel];
        case ($urandom_range(0, 2))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        rand_instr = w;
    endfunction

    // Advance the model by one edge using the inputs currently driven, then move to the next negedge.
    task automatic tick();
        logic [7:0] d;
        logic       acc;
        acc = in_valid && (!exp_valid || out_ready) && !flush;
        d   = ref_dec(in_instr);
        if (flush) begin
            exp_valid = 1'b0;
        end else if (acc) begin
            exp_valid = 1'b1;
            {exp_ill, exp_b, exp_a, exp_ctr} = d;
`ifdef ALU_ILLEGAL_CNT_EN
            if (d[7]) begin
                if (exp_cnt < 65535) exp_cnt++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
`endif
        end else if (out_ready) begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        in_instr = 32'h0;
        exp_valid = 1'b0;
        {exp_ill, exp_b, exp_a, exp_ctr} = 8'h00;
`ifdef ALU_ILLEGAL_CNT_EN
        exp_cnt = 0;
        exp_cnt2 = 0;
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({out_valid, out_ctr, out_src_a_sel, out_src_b_sel, out_illegal} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 000000000",
                     {out_valid, out_ctr, out_src_a_sel, out_src_b_sel, out_illegal});
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
`ifdef ALU_ILLEGAL_CNT_EN
        n_cmp++;
        if (cnt16 !== 16'd0) begin
            n_err++;
            $display("FAIL reset_cnt: got %0d want 0", cnt16);
        end
`endif
    endtask

    task automatic test_directed();
        logic [31:0] words [3];
        logic [8:0]  want  [3];
        words = '{32'h403100B3, 32'h40335293, 32'h40331293};
        // {valid, ctr, src_a, src_b, illegal}
        want  = '{{1'b1, SUB, 2'b00, 1'b0, 1'b0},
                  {1'b1, SRA, 2'b00, 1'b1, 1'b0},
                  {1'b1, ADD, 2'b00, 1'b0, 1'b1}};
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_instr = words[k];
            tick();
            n_cmp++;
            if ({out_valid, out_ctr, out_src_a_sel, out_src_b_sel, out_illegal} !== want[k]) begin
                n_err++;
                $display("FAIL directed_%08h: got %b want %b", words[k],
                         {out_valid, out_ctr, out_src_a_sel, out_src_b_sel, out_illegal}, want[k]);
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL directed_drain: got valid %b want 0", out_valid);
        end
    endtask

    task automatic test_stall();
        in_valid = 1'b1;
        in_instr = 32'h0000A083;
        out_ready = 1'b0;
        tick();
        in_instr = 32'h403100B3;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_in_ready[%0d]: got %b want 0", k, in_ready);
            end
            tick();
            n_cmp++;
            if ({out_valid, out_ctr, out_src_a_sel, out_src_b_sel, out_illegal} !==
                {1'b1, ADD, 2'b00, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got %b want 100000010", k,
                         {out_valid, out_ctr, out_src_a_sel, out_src_b_sel, out_illegal});
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release_ready: got %b want 1", in_ready);
        end
        tick();
        n_cmp++;
        if ({out_valid, out_ctr, out_src_b_sel} !== {1'b1, SUB, 1'b0}) begin
            n_err++;
            $display("FAIL stall_next_load: got %b want 110000", {out_valid, out_ctr, out_src_b_sel});
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        in_valid = 1'b1;
        in_instr = 32'h0000A083;
        out_ready = 1'b0;
        tick();
        in_instr = 32'h403100B3;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_kill: got valid %b want 0", out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_drop_incoming: got valid %b want 0", out_valid);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_illegal();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00000000;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if ({out_valid, out_ctr, out_illegal} !== {1'b1, 4'b0000, 1'b1}) begin
                n_err++;
                $display("FAIL illegal_zero[%0d]: got %b want 100001", k,
                         {out_valid, out_ctr, out_illegal});
            end
        end
`ifdef ALU_ILLEGAL_CNT_EN
        n_cmp++;
        if (cnt16 !== 16'd3) begin
            n_err++;
            $display("FAIL cnt_three: got %0d want 3", cnt16);
        end
        tick();
        tick();
        n_cmp++;
        if (cnt16 !== 16'd5 || cnt2 !== 2'd3) begin
            n_err++;
            $display("FAIL cnt_saturate: got %0d/%0d want 5/3", cnt16, cnt2);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if (cnt16 !== 16'd5) begin
            n_err++;
            $display("FAIL cnt_flush_suppress: got %0d want 5", cnt16);
        end
        tick();
`endif
        // Asynchronous reset between edges must clear the held entry at once.
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_valid: got %b want 0", out_valid);
        end
`ifdef ALU_ILLEGAL_CNT_EN
        n_cmp++;
        if (cnt16 !== 16'd0) begin
            n_err++;
            $display("FAIL async_reset_cnt: got %0d want 0", cnt16);
        end
`endif
        do_reset();
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = rand_instr();
        tick();
        for (int k = 0; k < 8; k++) begin
            prev = in_instr;
            in_instr = rand_instr();
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready[%0d]: got %b want 1", k, in_ready);
            end
            n_cmp++;
            if ({out_valid, out_illegal, out_src_b_sel, out_src_a_sel, out_ctr} !==
                {1'b1, ref_dec(prev)}) begin
                n_err++;
                $display("FAIL b2b_data[%0d] instr %08h: got %b want %b", k, prev,
                         {out_valid, out_illegal, out_src_b_sel, out_src_a_sel, out_ctr},
                         {1'b1, ref_dec(prev)});
            end
            tick();
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 9) == 0);
            in_instr  = rand_instr();
            #1;
            n_cmp++;
            if (in_ready !== (!exp_valid || out_ready)) begin
                n_err++;
                $display("FAIL rand_in_ready[%0d]: got %b want %b", k, in_ready,
                         (!exp_valid || out_ready));
            end
            tick();
            n_cmp++;
            if (out_valid !== exp_valid) begin
                n_err++;
                $display("FAIL rand_valid[%0d]: got %b want %b", k, out_valid, exp_valid);
            end else if (exp_valid && {out_illegal, out_src_b_sel, out_src_a_sel, out_ctr} !==
                         {exp_ill, exp_b, exp_a, exp_ctr}) begin
                n_err++;
                $display("FAIL rand_data[%0d]: got %b want %b", k,
                         {out_illegal, out_src_b_sel, out_src_a_sel, out_ctr},
                         {exp_ill, exp_b, exp_a, exp_ctr});
            end
`ifdef ALU_ILLEGAL_CNT_EN
            n_cmp++;
            if (cnt16 !== exp_cnt[15:0] || cnt2 !== exp_cnt2[1:0]) begin
                n_err++;
                $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", k, cnt16, cnt2,
                         exp_cnt, exp_cnt2);
            end
`endif
        end
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        in_instr = 32'h0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_stall();
        test_flush();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
